// File: rtl/mem_req_pkg.sv
// Shared types and constants for the memory request initiator.
// - mem_req_state_t : initiator FSM states
// - mem_cmd_t       : latched command (rnw, addr, wdata)
// - TO_CNT_W        : width of the saturating timeout counter
// - timer_width()   : counter width able to hold 0..n-1 (at least 1 bit)
package mem_req_pkg;

  localparam int TO_CNT_W   = 8;
  localparam int CMD_ADDR_W = 4;
  localparam int CMD_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, REQ, RSP, GAP} mem_req_state_t;

  typedef struct packed {
    logic                  rnw;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } mem_cmd_t;

  // A counter that must reach n-1 needs $clog2(n) bits; never less than one.
  function automatic int timer_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_req_timer.sv
// Clear/enable up-counter with a terminal-count flag.
// Ports:
// - clk, reset : clock, asynchronous active-high reset
// - clr_i      : synchronous clear (wins over enable)
// - en_i       : count up by one
// - tc_o       : high while the count equals TERMINAL
module mem_req_timer #(
  parameter int WIDTH    = 1,
  parameter int TERMINAL = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear has priority so the owner can restart on state entry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/mem_req_initiator.sv
// Requester for the req/ready memory interface.
// Takes one command at a time on the cmd valid/ready channel, holds a level
// request to the memory until it answers ready or TIMEOUT cycles pass, then
// returns exactly one response (read data or timeout error) on the rsp channel.
// A GAP_CYCLES low period after each response lets the memory see a fresh
// rising edge of req before the next request.
// Ports:
// - clk, reset                    : clock, asynchronous active-high reset
// - cmd_valid_i/cmd_ready_o       : command handshake; cmd_rnw_i/addr/wdata payload
// - req_o, req_rnw_o/addr/wdata   : memory request, held stable while req_o is high
// - mem_ready_i, mem_rdata_i      : memory completion and read data
// - rsp_valid_o/rsp_ready_i       : response handshake; rsp_rnw/rdata/err payload
// - to_cnt_o                      : saturating count of timeouts
// The command latch uses mem_cmd_t, so ADDR_W/DATA_W must stay at the package widths.
module mem_req_initiator
  import mem_req_pkg::*;
#(
  parameter int ADDR_W     = CMD_ADDR_W,
  parameter int DATA_W     = CMD_DATA_W,
  parameter int TIMEOUT    = 64,
  parameter int GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_rnw_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  output logic                req_o,
  output logic                req_rnw_o,
  output logic [ADDR_W-1:0]   req_addr_o,
  output logic [DATA_W-1:0]   req_wdata_o,
  input  logic                mem_ready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_rnw_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic [TO_CNT_W-1:0] to_cnt_o
);

  mem_req_state_t      state_q, state_d;
  mem_cmd_t            cmd_q, cmd_d;
  logic                rsp_rnw_q, rsp_rnw_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                to_expired;
  logic                gap_done;

  // Request timer: zero on the first REQ cycle, so reaching TIMEOUT-1 means
  // req_o has been high for exactly TIMEOUT cycles.
  mem_req_timer #(
    .WIDTH    (timer_width(TIMEOUT)),
    .TERMINAL (TIMEOUT - 1)
  ) u_to_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q != REQ),
    .en_i  (state_q == REQ),
    .tc_o  (to_expired)
  );

  // Gap timer: GAP is left after GAP_CYCLES cycles; unused when GAP_CYCLES is 0.
  mem_req_timer #(
    .WIDTH    (timer_width(GAP_CYCLES)),
    .TERMINAL ((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0)
  ) u_gap_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q != GAP),
    .en_i  (state_q == GAP),
    .tc_o  (gap_done)
  );

  // Next-state, command latch and response capture. Ready beats a same-cycle
  // timeout because it is tested first.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_rnw_d   = rsp_rnw_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    to_cnt_d    = to_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          cmd_d.rnw   = cmd_rnw_i;
          cmd_d.addr  = cmd_addr_i;
          cmd_d.wdata = cmd_wdata_i;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (mem_ready_i) begin
          rsp_rnw_d   = cmd_q.rnw;
          rsp_rdata_d = cmd_q.rnw ? mem_rdata_i : '0;
          rsp_err_d   = 1'b0;
          state_d     = RSP;
        end else if (to_expired) begin
          rsp_rnw_d   = cmd_q.rnw;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          if (to_cnt_q != '1) begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_rnw_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_rnw_q   <= rsp_rnw_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign req_o       = (state_q == REQ);
  assign req_rnw_o   = cmd_q.rnw;
  assign req_addr_o  = cmd_q.addr;
  assign req_wdata_o = cmd_q.wdata;
  assign rsp_valid_o = (state_q == RSP);
  assign rsp_rnw_o   = rsp_rnw_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign to_cnt_o    = to_cnt_q;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Testbench for mem_req_initiator with a behavioural memory stub
// (fixed, random or never-ready delay) and a transaction-level reference
// model of expected responses, request lengths and the timeout counter.
module tb_mem_req_initiator;

  localparam int TIMEOUT     = 8;
  localparam int GAP_CYCLES  = 1;
  localparam int MODE_FIXED  = 0;
  localparam int MODE_RANDOM = 1;
  localparam int MODE_NEVER  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid_i, cmd_ready_o, cmd_rnw_i;
  logic [3:0]  cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        req_o, req_rnw_o;
  logic [3:0]  req_addr_o;
  logic [31:0] req_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_rnw_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [7:0]  to_cnt_o;

  int          checks = 0;
  int          errors = 0;
  int          mem_mode = MODE_FIXED;
  int          fixed_delay = 0;
  int          cur_delay = 0;
  int          hi_cnt = 0;
  int          low_run = 0;
  int          gap_viol = 0;
  bit          seen_req = 1'b0;
  int          to_model = 0;
  logic [31:0] stub_mem [16];
  logic [31:0] ref_mem [16];

  always #5 clk = ~clk;

  mem_req_initiator #(
    .ADDR_W     (4),
    .DATA_W     (32),
    .TIMEOUT    (TIMEOUT),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_rnw_i   (cmd_rnw_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .req_o       (req_o),
    .req_rnw_o   (req_rnw_o),
    .req_addr_o  (req_addr_o),
    .req_wdata_o (req_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rnw_o   (rsp_rnw_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .to_cnt_o    (to_cnt_o)
  );

  // Memory stub: a new delay is picked while req is low; ready rises once req
  // has been high for that many earlier cycles. Writes land on the ready edge.
  always @(posedge clk) begin
    if (!req_o) begin
      hi_cnt    <= 0;
      cur_delay <= (mem_mode == MODE_RANDOM) ? int'($urandom_range(5, 0)) : fixed_delay;
    end else begin
      hi_cnt <= hi_cnt + 1;
    end
    if (req_o && mem_ready_i && !req_rnw_o) begin
      stub_mem[req_addr_o] <= req_wdata_o;
    end
  end

  // Ready and read data; outside a ready read the data bus carries junk.
  always_comb begin
    mem_ready_i = (mem_mode != MODE_NEVER) && req_o && (hi_cnt >= cur_delay);
    mem_rdata_i = (req_o && req_rnw_o && mem_ready_i) ? stub_mem[req_addr_o] : 32'h5A5A_C3C3;
  end

  // Counts cycles with req low between two requests and flags short gaps.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_req <= 1'b0;
      low_run  <= 0;
    end else if (req_o) begin
      if (seen_req && low_run > 0 && low_run < 1 + GAP_CYCLES) begin
        gap_viol <= gap_viol + 1;
      end
      seen_req <= 1'b1;
      low_run  <= 0;
    end else begin
      low_run <= low_run + 1;
    end
  end

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs one complete command/response transaction and checks it against the
  // reference model. hold = cycles rsp_ready_i stays low after rsp_valid_o.
  task automatic applyStimulus(input logic rnw, input logic [3:0] addr, input logic [31:0] wdata, input int hold);
    int          n;
    int          req_len;
    bit          stable;
    bit          quiet;
    logic        h_rnw, h_err;
    logic [31:0] h_rdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_rnw_i   = rnw;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    n = 0;
    while (!cmd_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_accept_bound", 32'(n < 100), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    cmd_rnw_i   = 1'($urandom);
    cmd_addr_i  = 4'($urandom);
    cmd_wdata_i = $urandom;
    req_len = 0;
    n = 0;
    while (!rsp_valid_o && n < 100) begin
      if (req_o) req_len++;
      @(negedge clk);
      n++;
    end
    checkOutput("rsp_valid_bound", 32'(n < 100), 32'd1);
    h_rnw   = rsp_rnw_o;
    h_err   = rsp_err_o;
    h_rdata = rsp_rdata_o;
    stable  = 1'b1;
    quiet   = 1'b1;
    if (hold > 0) cmd_valid_i = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      stable &= rsp_valid_o && (rsp_rnw_o === h_rnw) && (rsp_err_o === h_err) && (rsp_rdata_o === h_rdata);
      quiet  &= !req_o && !cmd_ready_o;
    end
    cmd_valid_i = 1'b0;
    if (hold > 0) begin
      checkOutput("rsp_hold_stable", 32'(stable), 32'd1);
      checkOutput("rsp_hold_no_req", 32'(quiet), 32'd1);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    checkOutput("rsp_valid_after_hs", 32'(rsp_valid_o), 32'd0);

    exp_err   = (mem_mode == MODE_NEVER);
    exp_rdata = (!exp_err && rnw) ? ref_mem[addr] : 32'd0;
    if (!exp_err && !rnw) ref_mem[addr] = wdata;
    if (exp_err && to_model < 255) to_model++;
    checkOutput("rsp_err", 32'(h_err), 32'(exp_err));
    checkOutput("rsp_rdata", h_rdata, exp_rdata);
    checkOutput("rsp_rnw", 32'(h_rnw), 32'(rnw));
    checkOutput("to_cnt", 32'(to_cnt_o), 32'(to_model));
    if (exp_err) begin
      checkOutput("req_len_timeout", 32'(req_len), 32'(TIMEOUT));
    end else if (mem_mode == MODE_FIXED) begin
      checkOutput("req_len_fixed", 32'(req_len), 32'(fixed_delay + 1));
    end else begin
      checkOutput("req_len_random", 32'(req_len >= 1 && req_len <= 6), 32'd1);
    end
  endtask

  // Directed sequence of scenarios.
  initial begin
    int n;
    reset       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_rnw_i   = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    checkOutput("rst_req", 32'(req_o), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst_to_cnt", 32'(to_cnt_o), 32'd0);
    checkOutput("rst_req_addr", 32'(req_addr_o), 32'd0);
    checkOutput("rst_req_wdata", req_wdata_o, 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    reset = 1'b0;

    // Write then read with a two-cycle memory delay.
    mem_mode    = MODE_FIXED;
    fixed_delay = 2;
    applyStimulus(1'b0, 4'h3, 32'hDEAD_BEEF, 0);
    applyStimulus(1'b1, 4'h3, 32'h0, 0);

    // Best-case latency with ready and rsp_ready tied high.
    fixed_delay = 0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    n = 0;
    while (!cmd_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("lat_idle_bound", 32'(n < 100), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_rnw_i   = 1'b1;
    cmd_addr_i  = 4'h3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    checkOutput("lat_n1_req", 32'(req_o), 32'd1);
    checkOutput("lat_n1_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("lat_n1_cmd_ready", 32'(cmd_ready_o), 32'd0);
    @(negedge clk);
    checkOutput("lat_n2_req", 32'(req_o), 32'd0);
    checkOutput("lat_n2_rsp_valid", 32'(rsp_valid_o), 32'd1);
    checkOutput("lat_n2_rdata", rsp_rdata_o, ref_mem[3]);
    @(negedge clk);
    checkOutput("lat_gap_cmd_ready", 32'(cmd_ready_o), 32'd0);
    checkOutput("lat_gap_req", 32'(req_o), 32'd0);
    @(negedge clk);
    checkOutput("lat_idle_cmd_ready", 32'(cmd_ready_o), 32'd1);
    rsp_ready_i = 1'b0;

    // Response back-pressure for five cycles.
    fixed_delay = 2;
    applyStimulus(1'b1, 4'h3, 32'h0, 5);

    // Single timeout.
    mem_mode = MODE_NEVER;
    applyStimulus(1'b1, 4'h7, 32'h0, 0);

    // All addresses with random memory delays and random back-pressure.
    mem_mode = MODE_RANDOM;
    for (int a = 0; a < 16; a++) applyStimulus(1'b0, 4'(a), 32'hA5A5_0000 + 32'(a), int'($urandom_range(3, 0)));
    for (int a = 0; a < 16; a++) applyStimulus(1'b1, 4'(a), 32'h0, int'($urandom_range(3, 0)));

    // Enough further timeouts to saturate the counter.
    mem_mode = MODE_NEVER;
    for (int k = 0; k < 299; k++) applyStimulus(1'($urandom), 4'($urandom), $urandom, 0);
    checkOutput("to_cnt_saturated", 32'(to_cnt_o), 32'hFF);
    checkOutput("req_low_gap", 32'(gap_viol), 32'd0);

    // Reset in the middle of a request.
    @(negedge clk);
    n = 0;
    while (!cmd_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    cmd_valid_i = 1'b1;
    cmd_rnw_i   = 1'b0;
    cmd_addr_i  = 4'h5;
    cmd_wdata_i = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid_req_before_reset", 32'(req_o), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_rst_req", 32'(req_o), 32'd0);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("mid_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    checkOutput("mid_rst_to_cnt", 32'(to_cnt_o), 32'd0);
    checkOutput("mid_rst_req_addr", 32'(req_addr_o), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    to_model = 0;

    // Normal operation after reset.
    mem_mode    = MODE_FIXED;
    fixed_delay = 1;
    applyStimulus(1'b1, 4'h5, 32'h0, 0);
    applyStimulus(1'b1, 4'h3, 32'h0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
